// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the D flip-flop BIST driver.
package dff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
  localparam logic [15:0] NO_FAIL     = 16'hFFFF;
  localparam int unsigned INIT_CYCLES = 2;
  localparam int unsigned PIPE_DEPTH  = 2;

  localparam int unsigned IDX_W = 16;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

  // One in-flight check: expected flop value tagged with its vector index.
  typedef struct packed {
    logic             valid;
    logic             expected;
    logic [IDX_W-1:0] index;
  } check_t;

  // An all-zero Fibonacci LFSR would lock up, so zero is promoted to one.
  function automatic logic [7:0] safe_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

  function automatic logic lfsr_feedback(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/dff_bist_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shift-left, with seed load.
module lfsr8
  import dff_bist_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  always_ff @(posedge clock) begin
    if (reset || load) begin
      state <= safe_seed(seed);
    end else if (advance) begin
      state <= {state[6:0], lfsr_feedback(state)};
    end
  end

endmodule

// File: rtl/dff_bist.sv
// In-system BIST for a D flip-flop with active-low synchronous clear:
// LFSR-driven stimulus, delayed reference check, pass/fail summary.
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int unsigned N_VECTORS = 64,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             dut_data,
  output logic             dut_clear,
  input  logic             dut_q,
  input  logic             dut_qnot,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic [IDX_W-1:0] first_fail_index
);

  localparam logic [IDX_W-1:0] N_VEC      = IDX_W'(N_VECTORS);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_DEPTH - 1);

  state_t                      state;
  logic [CNT_W-1:0]            phase_cnt;
  logic [IDX_W-1:0]            idx;
  check_t [PIPE_DEPTH-1:0]     pipe;
  logic [7:0]                  lfsr_state;

  logic   lfsr_load_c;
  logic   drive_c;
  logic   vec_clear_c;
  logic   vec_data_c;
  logic   fail_c;
  logic   lfsr_unused_c;
  check_t new_check_c;
  check_t tail_c;

  lfsr8 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load_c),
    .seed    (LFSR_SEED),
    .advance (drive_c),
    .state   (lfsr_state)
  );

  // Vector i is launched on the last INIT edge (i=0) or on RUN edges until all are out.
  always_comb begin
    lfsr_load_c   = 1'b0;
    drive_c       = 1'b0;
    vec_clear_c   = ~(&idx[2:0]);
    vec_data_c    = lfsr_state[0];
    lfsr_unused_c = ^lfsr_state[7:1];
    new_check_c   = '0;
    tail_c        = pipe[PIPE_DEPTH-1];
    fail_c        = 1'b0;

    if ((state == IDLE || state == DONE) && start) begin
      lfsr_load_c = 1'b1;
    end
    if (state == INIT && phase_cnt == INIT_LAST) begin
      drive_c = 1'b1;
    end
    if (state == RUN && idx != N_VEC) begin
      drive_c = 1'b1;
    end

    new_check_c.valid    = drive_c;
    new_check_c.expected = vec_clear_c & vec_data_c;
    new_check_c.index    = idx;

    // A vector counts once even when both Q and Qnot are wrong.
    fail_c = tail_c.valid &&
             ((dut_q != tail_c.expected) || (dut_qnot != ~tail_c.expected));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      phase_cnt        <= '0;
      idx              <= '0;
      pipe             <= '0;
      dut_data         <= 1'b0;
      dut_clear        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error_count      <= '0;
      first_fail_index <= NO_FAIL;
    end else begin
      pipe <= {pipe[PIPE_DEPTH-2:0], new_check_c};

      if (drive_c) begin
        dut_data  <= vec_data_c;
        dut_clear <= vec_clear_c;
        idx       <= idx + IDX_W'(1);
      end

      if (fail_c) begin
        if (error_count != ERR_MAX) begin
          error_count <= error_count + ERR_W'(1);
        end
        if (first_fail_index == NO_FAIL) begin
          first_fail_index <= tail_c.index;
        end
      end

      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= INIT;
            phase_cnt        <= '0;
            idx              <= '0;
            dut_data         <= 1'b0;
            dut_clear        <= 1'b0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            error_count      <= '0;
            first_fail_index <= NO_FAIL;
          end
        end
        INIT: begin
          if (phase_cnt == INIT_LAST) begin
            state     <= RUN;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (idx == N_VEC) begin
            state     <= DRAIN;
            phase_cnt <= '0;
          end
        end
        DRAIN: begin
          // Outputs hold the last vector while its check leaves the delay line.
          if (phase_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (error_count == '0) && !fail_c;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Directed bench for dff_bist: behavioural flop with injectable faults, two BIST sizes.
module tb_dff_bist;
  import dff_bist_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic start;
  int   mode;  // 0 good flop, 1 Q stuck at 0, 2 Qnot tied to Q

  logic        a_data, a_clear, a_q, a_qnot, a_busy, a_done, a_pass, a_ff;
  logic [7:0]  a_err;
  logic [15:0] a_ffi;
  logic        b_data, b_clear, b_q, b_qnot, b_busy, b_done, b_pass, b_ff;
  logic [7:0]  b_err;
  logic [15:0] b_ffi;

  int checks   = 0;
  int failures = 0;

  logic exp_data  [64];
  logic exp_clear [64];
  int   ones_all;
  int   ones_19;

  dff_bist #(.N_VECTORS(64), .LFSR_SEED(8'hA5)) u_a (
    .clock(clock), .reset(reset), .start(start),
    .dut_data(a_data), .dut_clear(a_clear), .dut_q(a_q), .dut_qnot(a_qnot),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .error_count(a_err), .first_fail_index(a_ffi)
  );

  dff_bist #(.N_VECTORS(300), .LFSR_SEED(8'hA5)) u_b (
    .clock(clock), .reset(reset), .start(start),
    .dut_data(b_data), .dut_clear(b_clear), .dut_q(b_q), .dut_qnot(b_qnot),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .error_count(b_err), .first_fail_index(b_ffi)
  );

  // Flop under test: synchronous active-low clear.
  always @(posedge clock) begin
    a_ff <= a_clear ? a_data : 1'b0;
    b_ff <= b_clear ? b_data : 1'b0;
  end
  assign a_q    = (mode == 1) ? 1'b0 : a_ff;
  assign a_qnot = (mode == 2) ? a_q  : ~a_ff;
  assign b_q    = (mode == 1) ? 1'b0 : b_ff;
  assign b_qnot = (mode == 2) ? b_q  : ~b_ff;

  task automatic build_model();
    logic [7:0] s;
    s = 8'hA5;
    ones_all = 0;
    ones_19  = 0;
    for (int i = 0; i < 64; i++) begin
      exp_clear[i] = ((i % 8) != 7);
      exp_data[i]  = s[0];
      if (exp_clear[i] && s[0]) begin
        ones_all++;
        if (i < 19) ones_19++;
      end
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
  endtask

  // Pulses start (sampled at edge 0) and waits for both instances' done.
  task automatic run(input bit stream, output logic busy0, output int a_edge, output int b_edge);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    busy0  = a_busy;
    a_edge = -1;
    b_edge = -1;
    for (int e = 1; e <= 400 && (a_edge < 0 || b_edge < 0); e++) begin
      @(posedge clock);
      #1;
      if (stream && e >= 2 && e <= 65) begin
        checks++;
        if (a_data !== exp_data[e-2] || a_clear !== exp_clear[e-2]) begin
          failures++;
          $display("FAIL stream_vec%0d got data=%0b clear=%0b exp data=%0b clear=%0b",
                   e - 2, a_data, a_clear, exp_data[e-2], exp_clear[e-2]);
        end
      end
      if (stream && e == 1) begin
        checks++;
        if (a_clear !== 1'b0 || a_data !== 1'b0) begin
          failures++;
          $display("FAIL init_drive got data=%0b clear=%0b exp 0 0", a_data, a_clear);
        end
      end
      if (a_done && a_edge < 0) a_edge = e;
      if (b_done && b_edge < 0) b_edge = e;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", a_done); end
    checks++; if (a_pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%0b exp=0", a_pass); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", a_err); end
    checks++; if (a_ffi !== 16'hFFFF) begin failures++; $display("FAIL reset_ffi got=%h exp=ffff", a_ffi); end
    checks++; if (a_clear !== 1'b0 || a_data !== 1'b0) begin failures++; $display("FAIL reset_drive got data=%0b clear=%0b exp 0 0", a_data, a_clear); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_good();
    logic busy0; int ae, be;
    mode = 0;
    run(1'b1, busy0, ae, be);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL good_busy_after_start got=%0b exp=1", busy0); end
    checks++; if (ae != 68) begin failures++; $display("FAIL good_done_edge got=%0d exp=68", ae); end
    checks++; if (a_pass !== 1'b1) begin failures++; $display("FAIL good_pass got=%0b exp=1", a_pass); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL good_err got=%0d exp=0", a_err); end
    checks++; if (a_ffi !== 16'hFFFF) begin failures++; $display("FAIL good_ffi got=%h exp=ffff", a_ffi); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL good_busy_done got=%0b exp=0", a_busy); end
    checks++; if (be != 304) begin failures++; $display("FAIL good300_done_edge got=%0d exp=304", be); end
    checks++; if (b_pass !== 1'b1) begin failures++; $display("FAIL good300_pass got=%0b exp=1", b_pass); end
  endtask

  task automatic test_stuck0();
    logic busy0; int ae, be;
    mode = 1;
    run(1'b0, busy0, ae, be);
    checks++; if (ae != 68) begin failures++; $display("FAIL stuck0_done_edge got=%0d exp=68", ae); end
    checks++; if (a_pass !== 1'b0) begin failures++; $display("FAIL stuck0_pass got=%0b exp=0", a_pass); end
    checks++; if (a_ffi !== 16'd0) begin failures++; $display("FAIL stuck0_ffi got=%0d exp=0", a_ffi); end
    checks++; if (a_err !== 8'(ones_all)) begin failures++; $display("FAIL stuck0_err got=%0d exp=%0d", a_err, ones_all); end
  endtask

  task automatic test_qnot_tied();
    logic busy0; int ae, be;
    mode = 2;
    run(1'b0, busy0, ae, be);
    checks++; if (a_err !== 8'd64) begin failures++; $display("FAIL tied_err got=%0d exp=64", a_err); end
    checks++; if (a_ffi !== 16'd0) begin failures++; $display("FAIL tied_ffi got=%0d exp=0", a_ffi); end
    checks++; if (a_pass !== 1'b0) begin failures++; $display("FAIL tied_pass got=%0b exp=0", a_pass); end
    checks++; if (b_err !== 8'd255) begin failures++; $display("FAIL tied300_err got=%0d exp=255", b_err); end
    checks++; if (be != 304) begin failures++; $display("FAIL tied300_done_edge got=%0d exp=304", be); end
    checks++; if (b_ffi !== 16'd0) begin failures++; $display("FAIL tied300_ffi got=%0d exp=0", b_ffi); end
  endtask

  task automatic test_reset_midrun();
    logic busy0; int ae, be;
    mode = 1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    // After edge 22 vector 20 is on the pins; vectors 0..18 have been checked.
    repeat (22) @(posedge clock);
    #1;
    checks++; if (a_err !== 8'(ones_19)) begin failures++; $display("FAIL midrun_err_before got=%0d exp=%0d", a_err, ones_19); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midrun_busy got=%0b exp=0", a_busy); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL midrun_err got=%0d exp=0", a_err); end
    checks++; if (a_clear !== 1'b0) begin failures++; $display("FAIL midrun_clear got=%0b exp=0", a_clear); end
    checks++; if (a_ffi !== 16'hFFFF) begin failures++; $display("FAIL midrun_ffi got=%h exp=ffff", a_ffi); end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (a_err !== 8'd0 || a_busy !== 1'b0) begin failures++; $display("FAIL midrun_idle got err=%0d busy=%0b exp 0 0", a_err, a_busy); end
    run(1'b0, busy0, ae, be);
    checks++; if (ae != 68) begin failures++; $display("FAIL rerun_done_edge got=%0d exp=68", ae); end
    checks++; if (a_err !== 8'(ones_all)) begin failures++; $display("FAIL rerun_err got=%0d exp=%0d", a_err, ones_all); end
    checks++; if (a_ffi !== 16'd0) begin failures++; $display("FAIL rerun_ffi got=%0d exp=0", a_ffi); end
  endtask

  task automatic test_start_held();
    int ae;
    mode = 2;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    ae = -1;
    for (int e = 1; e <= 200 && ae < 0; e++) begin
      @(posedge clock);
      #1;
      if (a_done) ae = e;
    end
    checks++; if (ae != 68) begin failures++; $display("FAIL held_done_edge got=%0d exp=68", ae); end
    checks++; if (a_err !== 8'd64) begin failures++; $display("FAIL held_err_done got=%0d exp=64", a_err); end
    @(posedge clock);
    #1;
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin failures++; $display("FAIL held_reenter got done=%0b busy=%0b exp 0 1", a_done, a_busy); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL held_err_clear got=%0d exp=0", a_err); end
    checks++; if (a_ffi !== 16'hFFFF) begin failures++; $display("FAIL held_ffi_clear got=%h exp=ffff", a_ffi); end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    mode  = 0;
    reset = 1'b1;
    start = 1'b0;
    build_model();
    test_reset();
    test_good();
    test_stuck0();
    test_qnot_tied();
    test_reset_midrun();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_bist.md
# dff_bist

Self-checking stimulus driver for a single-bit D flip-flop with active-low clear, on the same clock as the flop. It drives the flop's `data` and `clear` inputs from an 8-bit LFSR schedule and samples `Q`/`Qnot` against an internal reference model. It reports pass/fail, an error count and the first failing vector. It replaces bench-only stimulus so flop cells can be checked in-system.

## Interface
- `N_VECTORS`, default 64: number of checked vectors per run, 1..65535.
- `LFSR_SEED`, default 8'hA5: initial LFSR state; 8'h00 is replaced by 8'h01.
- `clock` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `start` input 1: level-sampled; begins a run from IDLE or DONE.
- `dut_data` output 1: drives flop `data`.
- `dut_clear` output 1: drives flop `clear`, active-low (0 forces Q=0).
- `dut_q` input 1: flop `Q`.
- `dut_qnot` input 1: flop `Qnot`.
- `busy` output 1: high in INIT, RUN, DRAIN.
- `done` output 1: high in DONE.
- `pass` output 1: valid when `done`; 1 iff `error_count`==0.
- `error_count` output 8: failing vectors; saturates at 255.
- `first_fail_index` output 16: index of first failing vector; 16'hFFFF if none.

## Operation
- Reset values:
  - state IDLE
  - `dut_data`=0, `dut_clear`=0
  - `busy`=0, `done`=0, `pass`=0
  - `error_count`=0, `first_fail_index`=16'hFFFF
  - LFSR=seed
  - vector index=0
- FSM: IDLE -> INIT -> RUN -> DRAIN -> DONE.
  - IDLE/DONE + `start` -> INIT. Clears `error_count`, `first_fail_index` and `pass`, reloads the LFSR and zeroes the index.
  - INIT, 2 cycles: `dut_clear`=0, `dut_data`=0. No checking.
  - RUN, exactly N_VECTORS cycles. Vector i drives `dut_data`=LFSR[0] and `dut_clear`=0 when i[2:0]==3'b111, else 1. The LFSR advances once per vector.
  - DRAIN, 2 cycles: outputs hold the last vector. The last two checks complete here.
  - DONE holds all results until `start` or `reset`.
- `start` while busy is ignored.
- LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shift left, feedback into bit 0 = b7^b5^b4^b3.
- Expected value of vector i: 0 if vector i has `dut_clear`=0, else the vector's `dut_data`.
- A vector fails if `dut_q`!=expected or `dut_qnot`!=~expected. A failing vector counts once, even if both outputs are wrong.
- On a failure: `error_count`+=1, saturating at 255. `first_fail_index` is written only while it still holds 16'hFFFF.
- `pass` is set on entering DONE.

## Timing
- `dut_data` and `dut_clear` are registered. Vector i is driven after edge t, the flop captures it at edge t+1, and the block samples `dut_q`/`dut_qnot` at edge t+2.
- The expected bit and index go through a 2-stage delay line with a valid bit. Valid is set only for RUN vectors, so INIT and DRAIN drive cycles are never checked.
- Latency: `start` sampled at edge 0 -> `busy` high after edge 0 -> `done` high after edge 4+N_VECTORS. That is edge 68 at the default.
- Counters and `first_fail_index` update at the edge where the check is sampled. `error_count` is final when `done` rises.
- `reset` mid-run: the next cycle is IDLE with all reset values, in-flight checks are discarded, and `dut_clear`=0.
- `reset` and `start` in the same cycle: reset wins.

## Structure
- Shared package `dff_bist_pkg`:
  - state enum (IDLE, INIT, RUN, DRAIN, DONE)
  - `LFSR_TAPS` = 8'hB8
  - `NO_FAIL` = 16'hFFFF
  - `INIT_CYCLES` = 2, `PIPE_DEPTH` = 2
- Sub-module `lfsr8`: ports `clock`, `reset`, `load`, `seed`, `advance`, `state[7:0]`. The parent contains the FSM, the delay line and the result registers.

## Test plan
- Behavioural good flop with synchronous active-low clear, defaults, `start` pulsed -> `done` at edge 68, `pass`=1, `error_count`=0, `first_fail_index`=16'hFFFF.
- Flop with Q stuck at 0 -> `pass`=0, `first_fail_index`=0 (seed bit0=1, no clear on vector 0), `error_count` equals the number of expected-1 vectors.
- `dut_qnot` tied to `dut_q` -> every vector fails: `error_count`=64, `first_fail_index`=0.
- N_VECTORS=300 with `dut_qnot` tied to `dut_q` -> `error_count` saturates at 255 and `done` arrives at edge 304.
- `reset` asserted in RUN at vector 20 -> the next cycle shows IDLE, `busy`=0, `error_count`=0, `dut_clear`=0. A re-`start` then gives the same result as a clean run.
- `start` held high throughout the run -> no restart while busy. One cycle of DONE is seen, then INIT re-enters, and the counters clear only at that re-entry.
